// File: rtl/bster_pkg.sv
// Shared types and helpers for the memory arbiter slice.
package bster_pkg;

  localparam int unsigned CMD_ADDR_W = 16;
  localparam int unsigned CMD_DATA_W = 32;

  // Width of a requester index; never below one bit.
  function automatic int unsigned req_id_w(input int unsigned nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

  // Command held in the output stage towards memory_driver.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wr_data;
  } mem_cmd_t;

endpackage

// File: rtl/rd_route_fifo.sv
// Records the requester index of each issued read, returned in issue order.
module rd_route_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointer comparison with a wrap bit distinguishes full from empty.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Next pointers and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // State registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin merge of NB_REQ requesters onto one memory_driver port,
// with in-order steering of returned read data.
module mem_arbiter
  import bster_pkg::*;
#(
  parameter int unsigned NB_REQ         = 2,
  parameter int unsigned RAM_ADDR_WIDTH = CMD_ADDR_W,
  parameter int unsigned RAM_DATA_WIDTH = CMD_DATA_W,
  parameter int unsigned MAX_OUTSTD     = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NB_REQ-1:0]                req_valid,
  output logic [NB_REQ-1:0]                req_ready,
  input  logic [NB_REQ-1:0]                req_rd,
  input  logic [NB_REQ-1:0]                req_wr,
  input  logic [NB_REQ*RAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NB_REQ*RAM_DATA_WIDTH-1:0] req_wr_data,
  output logic [NB_REQ-1:0]                req_rd_valid,
  input  logic [NB_REQ-1:0]                req_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0]        req_rd_data,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic                             mem_rd,
  output logic                             mem_wr,
  output logic [RAM_ADDR_WIDTH-1:0]        mem_addr,
  output logic [RAM_DATA_WIDTH-1:0]        mem_wr_data,
  input  logic                             mem_rd_valid,
  output logic                             mem_rd_ready,
  input  logic [RAM_DATA_WIDTH-1:0]        mem_rd_data,
  output logic                             rd_orphan
);

  localparam int unsigned ID_W = req_id_w(NB_REQ);

  mem_cmd_t          cmd_q, cmd_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              orphan_q, orphan_d;

  logic [NB_REQ-1:0] eligible;
  logic              load_en;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic              accept;

  logic              route_push;
  logic              route_pop;
  logic [ID_W-1:0]   route_head;
  logic              route_full;
  logic              route_empty;

  // A read may only be granted while a route slot is free.
  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      eligible[i] = req_valid[i] & (~req_rd[i] | ~route_full);
    end
  end

  // Round-robin scan from rr_ptr; grant only when the output stage can load.
  always_comb begin
    load_en   = ~valid_q | mem_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NB_REQ);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    req_ready = '0;
    if (load_en && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
    accept     = req_valid[gnt_idx] & req_ready[gnt_idx];
    route_push = accept & req_rd[gnt_idx];
  end

  // Output stage, rr pointer and sticky orphan flag next-state.
  always_comb begin
    cmd_d    = cmd_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    orphan_d = orphan_q | (mem_rd_valid & route_empty);
    if (load_en) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      rr_ptr_d = ID_W'((32'(gnt_idx) + 32'd1) % NB_REQ);
      // No-op commands are consumed without occupying the output stage.
      if (req_rd[gnt_idx] | req_wr[gnt_idx]) begin
        valid_d       = 1'b1;
        cmd_d.rd      = req_rd[gnt_idx];
        cmd_d.wr      = req_wr[gnt_idx];
        cmd_d.addr    = CMD_ADDR_W'(req_addr[gnt_idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]);
        cmd_d.wr_data = CMD_DATA_W'(req_wr_data[gnt_idx*RAM_DATA_WIDTH +: RAM_DATA_WIDTH]);
      end
    end
  end

  // State registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cmd_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= orphan_d;
    end
  end

  // Read data goes to the requester at the route head; unrouted data is dropped.
  always_comb begin
    req_rd_valid = '0;
    if (mem_rd_valid && !route_empty) begin
      req_rd_valid[route_head] = 1'b1;
    end
    mem_rd_ready = ~route_empty & req_rd_ready[route_head];
    route_pop    = mem_rd_valid & mem_rd_ready;
    req_rd_data  = mem_rd_data;
  end

  rd_route_fifo #(
    .DEPTH (MAX_OUTSTD),
    .WIDTH (ID_W)
  ) u_route (
    .aclk      (aclk),
    .areset    (areset),
    .push      (route_push),
    .push_data (gnt_idx),
    .pop       (route_pop),
    .head      (route_head),
    .full      (route_full),
    .empty     (route_empty)
  );

  assign mem_valid   = valid_q;
  assign mem_rd      = cmd_q.rd;
  assign mem_wr      = cmd_q.wr;
  assign mem_addr    = RAM_ADDR_WIDTH'(cmd_q.addr);
  assign mem_wr_data = RAM_DATA_WIDTH'(cmd_q.wr_data);
  assign rd_orphan   = orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, random vs model.
module tb_mem_arbiter;

  localparam int unsigned NB = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 8;

  localparam logic [AW-1:0] A0 = 16'h0A00;
  localparam logic [AW-1:0] A1 = 16'h0B11;
  localparam logic [DW-1:0] D0 = 32'hD0D0_0001;
  localparam logic [DW-1:0] D1 = 32'hD1D1_0002;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NB-1:0]     req_valid, req_ready, req_rd, req_wr;
  logic [NB*AW-1:0]  req_addr;
  logic [NB*DW-1:0]  req_wr_data;
  logic [NB-1:0]     req_rd_valid, req_rd_ready;
  logic [DW-1:0]     req_rd_data;
  logic              mem_valid, mem_ready, mem_rd, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wr_data;
  logic              mem_rd_valid, mem_rd_ready;
  logic [DW-1:0]     mem_rd_data;
  logic              rd_orphan;

  always #5 aclk = ~aclk;

  mem_arbiter #(
    .NB_REQ(NB), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .MAX_OUTSTD(MO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready), .req_rd_data(req_rd_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .rd_orphan(rd_orphan)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rd = '0; req_wr = '0;
    req_addr = '0; req_wr_data = '0; req_rd_ready = '0;
    mem_ready = 1'b1; mem_rd_valid = 1'b0; mem_rd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]    = a;
    req_wr_data[i*DW +: DW] = d;
  endtask

  typedef struct {
    logic [NB-1:0] valid;
    logic          mrdy;
    logic [NB-1:0] exp_rdy;
    logic          exp_mv;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[13];

  // Reference model state for the random phase.
  bit            m_valid;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_rr;
  int            m_q[$];
  bit            m_orph;

  initial begin
    int cnt;
    logic [NB-1:0] e_rdy, e_rrv;
    logic          e_mrr;
    int            g;

    // Writes from both requesters, then a 5-cycle stall, then drain.
    vecs[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, A0};
    vecs[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, A0};
    vecs[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, A1};
    vecs[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, A0};
    for (int i = 4; i < 9; i++) vecs[i] = '{2'b11, 1'b0, 2'b00, 1'b1, A1};
    vecs[9]  = '{2'b11, 1'b1, 2'b01, 1'b1, A1};
    vecs[10] = '{2'b11, 1'b1, 2'b10, 1'b1, A0};
    vecs[11] = '{2'b00, 1'b1, 2'b00, 1'b1, A1};
    vecs[12] = '{2'b00, 1'b1, 2'b00, 1'b0, A0};

    areset = 1'b0;
    do_reset();
    areset = 1'b1;
    settle();
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_rd_wr", 64'({mem_rd, mem_wr}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rd_valid", 64'(req_rd_valid), 64'd0);
    chk("rst_mem_rd_ready", 64'(mem_rd_ready), 64'd0);
    chk("rst_orphan", 64'(rd_orphan), 64'd0);
    areset = 1'b0;
    step();
    settle();
    chk("idle_req_ready", 64'(req_ready), 64'd0);
    chk("idle_mem_valid", 64'(mem_valid), 64'd0);
    step();

    // Table-driven write alternation and stall.
    set_req(0, A0, D0);
    set_req(1, A1, D1);
    req_wr = 2'b11;
    for (int i = 0; i < 13; i++) begin
      req_valid = vecs[i].valid;
      mem_ready = vecs[i].mrdy;
      settle();
      chk($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_mem_valid", i), 64'(mem_valid), 64'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) begin
        chk($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_mem_wr_data", i), 64'(mem_wr_data),
            64'((vecs[i].exp_addr == A0) ? D0 : D1));
        chk($sformatf("vec%0d_mem_rd_wr", i), 64'({mem_rd, mem_wr}), 64'd1);
      end
      step();
    end

    // Fill the route FIFO from requester 1; the 9th read stalls, a write still goes.
    do_reset();
    set_req(0, A0, D0);
    set_req(1, A1, D1);
    req_valid = 2'b10; req_rd = 2'b10;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (req_ready == 2'b10) cnt++;
      step();
    end
    chk("fill_accepts", 64'(cnt), 64'd8);
    req_valid = 2'b11; req_wr = 2'b01;
    settle();
    chk("full_read_stall_write_go", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b10;
    settle();
    chk("full_write_forwarded", 64'({mem_valid, mem_rd, mem_wr}), 64'b101);
    chk("full_write_addr", 64'(mem_addr), 64'(A0));
    chk("full_still_stalled", 64'(req_ready), 64'b00);
    step();

    // Reset with reads outstanding, then reads r0,r1,r0 and in-order returns.
    do_reset();
    req_valid = 2'b01; req_rd = 2'b01;
    settle();
    chk("order_issue0", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b10; req_rd = 2'b10;
    settle();
    chk("order_issue1", 64'(req_ready), 64'b10);
    step();
    req_valid = 2'b01; req_rd = 2'b01;
    settle();
    chk("order_issue2", 64'(req_ready), 64'b01);
    step();
    req_valid = '0; req_rd = '0;
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDA7A_0000; req_rd_ready = 2'b11;
    settle();
    chk("ret0_valid", 64'(req_rd_valid), 64'b01);
    chk("ret0_ready", 64'(mem_rd_ready), 64'd1);
    chk("ret0_data", 64'(req_rd_data), 64'h0DA7A_0000);
    step();
    mem_rd_data = 32'hDA7A_0001; req_rd_ready = 2'b01;
    settle();
    chk("ret1_stall_valid", 64'(req_rd_valid), 64'b10);
    chk("ret1_stall_ready", 64'(mem_rd_ready), 64'd0);
    step();
    req_rd_ready = 2'b11;
    settle();
    chk("ret1_valid", 64'(req_rd_valid), 64'b10);
    chk("ret1_ready", 64'(mem_rd_ready), 64'd1);
    chk("ret1_data", 64'(req_rd_data), 64'h0DA7A_0001);
    step();
    mem_rd_data = 32'hDA7A_0002;
    settle();
    chk("ret2_valid", 64'(req_rd_valid), 64'b01);
    chk("ret2_ready", 64'(mem_rd_ready), 64'd1);
    step();

    // Orphan read data with nothing outstanding.
    mem_rd_data = 32'hBAD0_0000;
    settle();
    chk("orphan_rd_ready", 64'(mem_rd_ready), 64'd0);
    chk("orphan_rd_valid", 64'(req_rd_valid), 64'd0);
    chk("orphan_not_yet", 64'(rd_orphan), 64'd0);
    step();
    mem_rd_valid = 1'b0;
    settle();
    chk("orphan_set", 64'(rd_orphan), 64'd1);
    step(); step(); step();
    settle();
    chk("orphan_sticky", 64'(rd_orphan), 64'd1);
    do_reset();
    settle();
    chk("orphan_cleared", 64'(rd_orphan), 64'd0);

    // Randomized traffic against a queue-based model of the arbitration rules.
    do_reset();
    m_valid = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_data = '0;
    m_rr = 0; m_q.delete(); m_orph = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_valid = NB'($urandom);
      req_rd    = NB'($urandom);
      req_wr    = NB'($urandom);
      for (int i = 0; i < NB; i++) set_req(i, AW'($urandom), DW'($urandom));
      mem_ready    = ($urandom_range(0, 3) != 0);
      mem_rd_valid = ($urandom_range(0, 2) == 0);
      mem_rd_data  = DW'($urandom);
      req_rd_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      settle();

      g = -1;
      if (!m_valid || mem_ready) begin
        for (int k = 0; k < NB; k++) begin
          int i;
          i = (m_rr + k) % NB;
          if (g < 0 && req_valid[i] && !(req_rd[i] && m_q.size() == MO)) g = i;
        end
      end
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      e_rrv = '0;
      e_mrr = 1'b0;
      if (m_q.size() > 0) begin
        if (mem_rd_valid) e_rrv[m_q[0]] = 1'b1;
        e_mrr = req_rd_ready[m_q[0]];
      end

      chk("rnd_req_ready", 64'(req_ready), 64'(e_rdy));
      chk("rnd_mem_valid", 64'(mem_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_mem_cmd", 64'({mem_rd, mem_wr, mem_addr}), 64'({m_rd, m_wr, m_addr}));
        chk("rnd_mem_wr_data", 64'(mem_wr_data), 64'(m_data));
      end
      chk("rnd_rd_valid", 64'(req_rd_valid), 64'(e_rrv));
      chk("rnd_mem_rd_ready", 64'(mem_rd_ready), 64'(e_mrr));
      chk("rnd_rd_data", 64'(req_rd_data), 64'(mem_rd_data));
      chk("rnd_orphan", 64'(rd_orphan), 64'(m_orph));

      if (mem_rd_valid && m_q.size() == 0) m_orph = 1;
      if (mem_rd_valid && e_mrr) void'(m_q.pop_front());
      if (!m_valid || mem_ready) m_valid = 0;
      if (g >= 0) begin
        m_rr = (g + 1) % NB;
        if (req_rd[g]) m_q.push_back(g);
        if (req_rd[g] || req_wr[g]) begin
          m_valid = 1;
          m_rd    = req_rd[g];
          m_wr    = req_wr[g];
          m_addr  = req_addr[g*AW +: AW];
          m_data  = req_wr_data[g*DW +: DW];
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
